// File: rtl/alu_datapath.sv
// Execute-stage datapath slice: operand-B mux, add/sub ALU,
// write-back mux and the Z/C flag register used by jnz.
//
// Ports:
//   clk, reset     rising-edge clock, async active-high reset
//   a              operand A (regfile read port 0)
//   reg_b, imm     operand-B sources (b_sel: 0=reg_b, 1=imm)
//   subtract       0=add, 1=subtract (a + ~b + 1)
//   flags_en       capture zero/cout into flag_z/flag_c
//   wb_sel         0=result 1=imm 2=load_data 3=a
//   load_data      memory load data
//   alu_b          selected operand B
//   result/cout    ALU sum and carry (cout=1: no borrow)
//   zero           result == 0
//   wb_data        regfile write data
//   flag_z/flag_c  registered flags
module alu_datapath #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] a,
    input  logic [DATA_BITS-1:0] reg_b,
    input  logic [DATA_BITS-1:0] imm,
    input  logic                 b_sel,
    input  logic                 subtract,
    input  logic                 flags_en,
    input  logic [1:0]           wb_sel,
    input  logic [DATA_BITS-1:0] load_data,
    output logic [DATA_BITS-1:0] alu_b,
    output logic [DATA_BITS-1:0] result,
    output logic                 cout,
    output logic                 zero,
    output logic [DATA_BITS-1:0] wb_data,
    output logic                 flag_z,
    output logic                 flag_c
);

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_IMM = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;
    localparam logic [1:0] WB_RD0 = 2'd3;

    logic [DATA_BITS-1:0] b_mux;
    logic [DATA_BITS-1:0] b_eff;
    logic [DATA_BITS:0]   sum;
    logic [DATA_BITS-1:0] sum_lo;
    logic                 sum_zero;
    logic [DATA_BITS-1:0] wb_mux;

    logic flag_z_d, flag_z_q;
    logic flag_c_d, flag_c_q;

    // Subtract reuses the adder: invert B and
    // feed subtract in as the carry-in.
    always_comb begin
        b_mux = b_sel ? imm : reg_b;
        b_eff = subtract ? ~b_mux : b_mux;
        sum = {1'b0, a}
            + {1'b0, b_eff}
            + {{DATA_BITS{1'b0}}, subtract};
        sum_lo   = sum[DATA_BITS-1:0];
        sum_zero = (sum_lo == '0);
    end

    always_comb begin
        wb_mux = sum_lo;
        unique case (wb_sel)
            WB_ALU:  wb_mux = sum_lo;
            WB_IMM:  wb_mux = imm;
            WB_MEM:  wb_mux = load_data;
            WB_RD0:  wb_mux = a;
            default: wb_mux = sum_lo;
        endcase
    end

    // Outputs read as all-zero while reset is held,
    // so downstream writes see no stale data.
    always_comb begin
        alu_b   = '0;
        result  = '0;
        cout    = 1'b0;
        zero    = 1'b0;
        wb_data = '0;
        if (!reset) begin
            alu_b   = b_mux;
            result  = sum_lo;
            cout    = sum[DATA_BITS];
            zero    = sum_zero;
            wb_data = wb_mux;
        end
    end

    always_comb begin
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        if (flags_en) begin
            flag_z_d = sum_zero;
            flag_c_d = sum[DATA_BITS];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath.
// Hand-computed vectors, one task per scenario.
module tb_alu_datapath;

    logic       clk;
    logic       reset;
    logic [7:0] a;
    logic [7:0] reg_b;
    logic [7:0] imm;
    logic       b_sel;
    logic       subtract;
    logic       flags_en;
    logic [1:0] wb_sel;
    logic [7:0] load_data;
    logic [7:0] alu_b;
    logic [7:0] result;
    logic       cout;
    logic       zero;
    logic [7:0] wb_data;
    logic       flag_z;
    logic       flag_c;

    int n_pass;
    int n_total;

    alu_datapath #(.DATA_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .reg_b     (reg_b),
        .imm       (imm),
        .b_sel     (b_sel),
        .subtract  (subtract),
        .flags_en  (flags_en),
        .wb_sel    (wb_sel),
        .load_data (load_data),
        .alu_b     (alu_b),
        .result    (result),
        .cout      (cout),
        .zero      (zero),
        .wb_data   (wb_data),
        .flag_z    (flag_z),
        .flag_c    (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        a = 8'h12; reg_b = 8'h34; imm = 8'h56;
        b_sel = 1'b0; subtract = 1'b0;
        flags_en = 1'b1; wb_sel = 2'd2;
        load_data = 8'h78;
        #1;
        n_total++;
        if (result !== 8'h00) $display("FAIL rst_result got %h exp 00", result);
        else n_pass++;
        n_total++;
        if (cout !== 1'b0) $display("FAIL rst_cout got %b exp 0", cout);
        else n_pass++;
        n_total++;
        if (zero !== 1'b0) $display("FAIL rst_zero got %b exp 0", zero);
        else n_pass++;
        n_total++;
        if (alu_b !== 8'h00) $display("FAIL rst_alu_b got %h exp 00", alu_b);
        else n_pass++;
        n_total++;
        if (wb_data !== 8'h00) $display("FAIL rst_wb got %h exp 00", wb_data);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if ({flag_z, flag_c} !== 2'b00)
            $display("FAIL rst_flags got %b exp 00", {flag_z, flag_c});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        flags_en = 1'b0;
    endtask

    task automatic test_add_regs();
        @(negedge clk);
        a = 8'h12; reg_b = 8'h34; imm = 8'hEE;
        b_sel = 1'b0; subtract = 1'b0; wb_sel = 2'd0;
        #1;
        n_total++;
        if (alu_b !== 8'h34) $display("FAIL add_alu_b got %h exp 34", alu_b);
        else n_pass++;
        n_total++;
        if (result !== 8'h46) $display("FAIL add_result got %h exp 46", result);
        else n_pass++;
        n_total++;
        if ({cout, zero} !== 2'b00)
            $display("FAIL add_cz got %b exp 00", {cout, zero});
        else n_pass++;
        n_total++;
        if (wb_data !== 8'h46) $display("FAIL add_wb got %h exp 46", wb_data);
        else n_pass++;
    endtask

    task automatic test_add_wrap();
        @(negedge clk);
        a = 8'hFF; imm = 8'h01; reg_b = 8'h80;
        b_sel = 1'b1; subtract = 1'b0; flags_en = 1'b1;
        #1;
        n_total++;
        if (alu_b !== 8'h01) $display("FAIL wrap_alu_b got %h exp 01", alu_b);
        else n_pass++;
        n_total++;
        if (result !== 8'h00) $display("FAIL wrap_result got %h exp 00", result);
        else n_pass++;
        n_total++;
        if ({cout, zero} !== 2'b11)
            $display("FAIL wrap_cz got %b exp 11", {cout, zero});
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if ({flag_z, flag_c} !== 2'b11)
            $display("FAIL wrap_flags got %b exp 11", {flag_z, flag_c});
        else n_pass++;
        flags_en = 1'b0;
    endtask

    task automatic test_sub();
        @(negedge clk);
        a = 8'h05; reg_b = 8'h05; imm = 8'h00;
        b_sel = 1'b0; subtract = 1'b1; wb_sel = 2'd0;
        #1;
        n_total++;
        if (result !== 8'h00) $display("FAIL sub_eq_result got %h exp 00", result);
        else n_pass++;
        n_total++;
        if ({cout, zero} !== 2'b11)
            $display("FAIL sub_eq_cz got %b exp 11", {cout, zero});
        else n_pass++;
        a = 8'h03;
        #1;
        n_total++;
        if (result !== 8'hFE) $display("FAIL sub_bor_result got %h exp fe", result);
        else n_pass++;
        n_total++;
        if ({cout, zero} !== 2'b00)
            $display("FAIL sub_bor_cz got %b exp 00", {cout, zero});
        else n_pass++;
        a = 8'h40; imm = 8'h10; b_sel = 1'b1;
        #1;
        n_total++;
        if ({cout, result} !== 9'h130)
            $display("FAIL sub_imm got %h exp 130", {cout, result});
        else n_pass++;
    endtask

    task automatic test_wb_mux();
        logic [7:0] exp_wb [4];
        exp_wb[0] = 8'h53;
        exp_wb[1] = 8'hB2;
        exp_wb[2] = 8'hC3;
        exp_wb[3] = 8'hA1;
        @(negedge clk);
        a = 8'hA1; imm = 8'hB2; load_data = 8'hC3;
        b_sel = 1'b1; subtract = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_sel = i[1:0];
            #1;
            n_total++;
            if (wb_data !== exp_wb[i])
                $display("FAIL wb_sel%0d got %h exp %h", i, wb_data, exp_wb[i]);
            else n_pass++;
        end
    endtask

    task automatic test_flag_hold();
        @(negedge clk);
        a = 8'h00; reg_b = 8'h00; b_sel = 1'b0;
        subtract = 1'b0; flags_en = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({flag_z, flag_c} !== 2'b10)
            $display("FAIL hold_set got %b exp 10", {flag_z, flag_c});
        else n_pass++;
        @(negedge clk);
        a = 8'hF0; reg_b = 8'h20; flags_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_total++;
            if ({flag_z, flag_c} !== 2'b10)
                $display("FAIL hold_edge%0d got %b exp 10", i, {flag_z, flag_c});
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        b_sel = 1'b0; subtract = 1'b1; flags_en = 1'b1;
        a = 8'h03; reg_b = 8'h05;
        @(posedge clk); #1;
        n_total++;
        if ({flag_z, flag_c} !== 2'b00)
            $display("FAIL b2b_0 got %b exp 00", {flag_z, flag_c});
        else n_pass++;
        a = 8'h05;
        @(posedge clk); #1;
        n_total++;
        if ({flag_z, flag_c} !== 2'b11)
            $display("FAIL b2b_1 got %b exp 11", {flag_z, flag_c});
        else n_pass++;
        subtract = 1'b0; a = 8'h80; reg_b = 8'h81;
        @(posedge clk); #1;
        n_total++;
        if ({flag_z, flag_c} !== 2'b01)
            $display("FAIL b2b_2 got %b exp 01", {flag_z, flag_c});
        else n_pass++;
        a = 8'hFF; reg_b = 8'h01;
        @(posedge clk); #1;
        flags_en = 1'b0;
    endtask

    task automatic test_async_reset();
        @(posedge clk); #2;
        n_total++;
        if ({flag_z, flag_c} !== 2'b11)
            $display("FAIL ar_pre got %b exp 11", {flag_z, flag_c});
        else n_pass++;
        a = 8'h10; reg_b = 8'h20; b_sel = 1'b0;
        subtract = 1'b0; wb_sel = 2'd0;
        reset = 1'b1;
        #1;
        n_total++;
        if ({flag_z, flag_c} !== 2'b00)
            $display("FAIL ar_flags got %b exp 00", {flag_z, flag_c});
        else n_pass++;
        n_total++;
        if (result !== 8'h00) $display("FAIL ar_result got %h exp 00", result);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if (result !== 8'h30) $display("FAIL ar_rel_result got %h exp 30", result);
        else n_pass++;
        n_total++;
        if (wb_data !== 8'h30) $display("FAIL ar_rel_wb got %h exp 30", wb_data);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if ({flag_z, flag_c} !== 2'b00)
            $display("FAIL ar_rel_flags got %b exp 00", {flag_z, flag_c});
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        a = '0; reg_b = '0; imm = '0;
        b_sel = 1'b0; subtract = 1'b0; flags_en = 1'b0;
        wb_sel = 2'd0; load_data = '0;
        test_reset();
        test_add_regs();
        test_add_wrap();
        test_sub();
        test_wb_mux();
        test_flag_hold();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
